ram_seq_init_write_ctrl: RTL and testbench
==========================================

Name: ram_seq_init_write_ctrl

Overview:
- Write-side front end placed between the write clients and the write ports of a multi-ported configurable RAM.
- After reset, or on request, it fills every RAM entry sequentially through the RAM's own write ports, several entries per cycle. Each entry receives zero or SEQ_START+index.
- While the fill runs it blocks client writes. When the fill completes it passes client writes straight through and raises ramReady_o.
- Replaces the single-cycle flop reset of the whole array, so latch/SRAM arrays can be built without per-entry reset.

Parameters:
- DEPTH, 32: number of RAM entries.
- INDEX, 5: address width, log2(DEPTH).
- WIDTH, 8: data width.
- NUM_WR_PORTS, 4: number of RAM write ports.
- INIT_LANES, 4: write ports used for the fill, lanes 0..INIT_LANES-1. Constraints: 1 <= INIT_LANES <= NUM_WR_PORTS, and DEPTH % INIT_LANES == 0; an elaboration-time check enforces both.
- RESET_VAL, 0: 0 = fill with zero; 1 = fill with sequence.
- SEQ_START, 0: first value of the sequence fill.

Ports:
- clk, in, 1: clock.
- reset, in, 1: synchronous, active-high reset.
- reinit_i, in, 1: request a new fill; sampled on the clk edge.
- wrEn_i, in, NUM_WR_PORTS: client write enables.
- addrWr_i, in, NUM_WR_PORTS x INDEX: client write addresses.
- dataWr_i, in, NUM_WR_PORTS x WIDTH: client write data.
- wrEn_o, out, NUM_WR_PORTS: write enables to the RAM.
- addrWr_o, out, NUM_WR_PORTS x INDEX: write addresses to the RAM.
- dataWr_o, out, NUM_WR_PORTS x WIDTH: write data to the RAM.
- ramReady_o, out, 1: RAM contents valid; client writes are accepted.
- initBusy_o, out, 1: fill in progress.
- wrDropped_o, out, 1: a client write was discarded this cycle.

Behaviour:
- Clock and reset: single clock clk. reset is synchronous and active-high and has priority over all other inputs.
- State: 2-state FSM {INIT, READY} plus fill pointer ptr, INDEX bits wide, always a multiple of INIT_LANES.
- Reset values: state=INIT, ptr=0.
- Outputs while reset=1: wrEn_o=0, ramReady_o=0, initBusy_o=0, wrDropped_o=0. No fill writes are issued during reset.
- INIT state, reset=0 (outputs are combinational from state and ptr):
  - Fill lanes l < INIT_LANES: wrEn_o[l]=1, addrWr_o[l]=ptr+l.
  - dataWr_o[l] = 0 when RESET_VAL=0, else (SEQ_START+ptr+l) mod 2^WIDTH.
  - Lanes l >= INIT_LANES: wrEn_o[l]=0; addr and data are don't-care, driven 0.
  - initBusy_o=1, ramReady_o=0.
  - wrDropped_o = OR of wrEn_i. Client writes are never forwarded and never queued.
- INIT transitions:
  - ptr <= ptr+INIT_LANES.
  - When ptr == DEPTH-INIT_LANES, the next state is READY and ptr <= 0.
  - Fill latency: exactly DEPTH/INIT_LANES cycles with wrEn_o active after reset deasserts. ramReady_o rises in the following cycle.
- READY state:
  - Pure combinational pass-through: wrEn_o=wrEn_i, addrWr_o=addrWr_i, dataWr_o=dataWr_i.
  - ramReady_o=1, initBusy_o=0, wrDropped_o=0.
- reinit_i in READY:
  - The current cycle is still a READY pass-through.
  - Next state is INIT with ptr=0, so the fill starts on the next cycle.
- reinit_i in INIT: ptr <= 0, so the fill restarts from entry 0. The current cycle's fill writes are still issued.
- reinit_i together with reset: reset wins. Result is the same, INIT with ptr=0.
- Reset mid-fill: ptr returns to 0 and the full fill reruns. Partially written entries are overwritten.
- Duplicate client addresses in READY are not resolved here. The RAM's port priority (highest port wins) applies.
- The address ptr+l never exceeds DEPTH-1 because of the divisibility constraint. No wrap logic is required.

Test Plan:
- Zero fill, defaults (DEPTH=32, INIT_LANES=4, RESET_VAL=0):
  - Stimulus: reset high 2 cycles, then low.
  - Required: 8 cycles of wrEn_o=4'b1111 with addr {0,1,2,3}, {4..7}, ..., {28..31}, all data 0.
  - Required: ramReady_o=1 on cycle 9; a RAM read of every entry returns 0.
- Sequence fill with truncation (RESET_VAL=1, SEQ_START=250, WIDTH=8):
  - Required: entry 0=250, entry 5=255, entry 6=0, entry 31=25.
- Client writes during fill:
  - Stimulus: wrEn_i=4'b0001, addr 3, data 0xAA on fill cycle 2.
  - Required: wrDropped_o=1 that cycle; entry 3 still holds its fill value after ready.
- Pass-through in READY:
  - Stimulus: wrEn_i=4'b1010, addr {7,9}, data {0x11,0x22}.
  - Required: the same values appear on wrEn_o/addrWr_o/dataWr_o in the same cycle; the RAM then reads entry 7=0x11 and entry 9=0x22.
- reinit_i mid-fill:
  - Stimulus: pulse reinit_i at fill cycle 5.
  - Required: the ptr sequence is 0,4,8,12,16,20 then 0,4,...,28; ramReady_o rises 14 cycles after reset release.
- reinit_i in READY, and INIT_LANES=1 variant:
  - Stimulus: reinit_i pulse in READY.
  - Required: ramReady_o falls next cycle, and the fill takes 32 cycles with only lane 0 active.
  - Required: wrEn_o[3:1] stays 0 throughout the fill.

Source files
------------

// File: rtl/ram_seq_init_write_ctrl.sv
// Write-side front end for a multi-ported RAM: fills every entry through the RAM's own
// write ports after reset or on request, then passes client writes straight through.
module ram_seq_init_write_ctrl #(
    parameter int unsigned DEPTH        = 32,
    parameter int unsigned INDEX        = 5,
    parameter int unsigned WIDTH        = 8,
    parameter int unsigned NUM_WR_PORTS = 4,
    parameter int unsigned INIT_LANES   = 4,
    parameter bit          RESET_VAL    = 1'b0,
    parameter int unsigned SEQ_START    = 0
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 reinit_i,
    input  logic [NUM_WR_PORTS-1:0]              wrEn_i,
    input  logic [NUM_WR_PORTS-1:0][INDEX-1:0]   addrWr_i,
    input  logic [NUM_WR_PORTS-1:0][WIDTH-1:0]   dataWr_i,
    output logic [NUM_WR_PORTS-1:0]              wrEn_o,
    output logic [NUM_WR_PORTS-1:0][INDEX-1:0]   addrWr_o,
    output logic [NUM_WR_PORTS-1:0][WIDTH-1:0]   dataWr_o,
    output logic                                 ramReady_o,
    output logic                                 initBusy_o,
    output logic                                 wrDropped_o
);

    if (INIT_LANES < 1 || INIT_LANES > NUM_WR_PORTS || (DEPTH % INIT_LANES) != 0) begin : g_bad_cfg
        $error("ram_seq_init_write_ctrl: INIT_LANES must be in 1..NUM_WR_PORTS and divide DEPTH");
    end

    typedef enum logic {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } state_e;

    localparam logic [INDEX-1:0] PTR_STEP = INDEX'(INIT_LANES);
    localparam logic [INDEX-1:0] PTR_LAST = INDEX'(DEPTH - INIT_LANES);

    state_e           state_q, state_d;
    logic [INDEX-1:0] ptr_q, ptr_d;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_INIT;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    // NOTE: every combinational output gets a default first so no path infers a latch.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        unique case (state_q)
            ST_INIT: begin
                if (reinit_i) begin
                    ptr_d = '0;
                end else if (ptr_q == PTR_LAST) begin
                    state_d = ST_READY;
                    ptr_d   = '0;
                end else begin
                    ptr_d = ptr_q + PTR_STEP;
                end
            end
            ST_READY: begin
                if (reinit_i) begin
                    state_d = ST_INIT;
                    ptr_d   = '0;
                end
            end
        endcase
    end

    // Fill lanes own ports 0..INIT_LANES-1; the remaining ports sit idle during a fill.
    always_comb begin
        wrEn_o      = '0;
        addrWr_o    = '0;
        dataWr_o    = '0;
        ramReady_o  = 1'b0;
        initBusy_o  = 1'b0;
        wrDropped_o = 1'b0;
        if (!reset) begin
            unique case (state_q)
                ST_INIT: begin
                    for (int l = 0; l < NUM_WR_PORTS; l++) begin
                        if (l < INIT_LANES) begin
                            wrEn_o[l]   = 1'b1;
                            addrWr_o[l] = ptr_q + INDEX'(l);
                            if (RESET_VAL) begin
                                dataWr_o[l] = WIDTH'(SEQ_START + 32'(ptr_q) + 32'(l));
                            end
                        end
                    end
                    initBusy_o  = 1'b1;
                    wrDropped_o = |wrEn_i;
                end
                ST_READY: begin
                    wrEn_o     = wrEn_i;
                    addrWr_o   = addrWr_i;
                    dataWr_o   = dataWr_i;
                    ramReady_o = 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_seq_init_write_ctrl.sv
// Directed bench: three instances (zero fill, wrapping sequence fill, single-lane fill)
// each feeding a small RAM model that applies writes with highest-port-wins priority.
module tb_ram_seq_init_write_ctrl;

    localparam int W  = 8;
    localparam int IX = 5;
    localparam int NP = 4;
    localparam int D  = 32;

    typedef logic [NP-1:0][IX-1:0] addr_vec_t;
    typedef logic [NP-1:0][W-1:0]  data_vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Instance A: zero fill, four lanes
    logic reset_a, reinit_a, ready_a, busy_a, drop_a;
    logic [NP-1:0] we_i_a, we_o_a;
    addr_vec_t addr_i_a, addr_o_a;
    data_vec_t data_i_a, data_o_a;

    ram_seq_init_write_ctrl #(.DEPTH(D), .INDEX(IX), .WIDTH(W), .NUM_WR_PORTS(NP),
                              .INIT_LANES(4), .RESET_VAL(1'b0), .SEQ_START(0)) u_dut_a (
        .clk(clk), .reset(reset_a), .reinit_i(reinit_a),
        .wrEn_i(we_i_a), .addrWr_i(addr_i_a), .dataWr_i(data_i_a),
        .wrEn_o(we_o_a), .addrWr_o(addr_o_a), .dataWr_o(data_o_a),
        .ramReady_o(ready_a), .initBusy_o(busy_a), .wrDropped_o(drop_a)
    );

    // Instance B: sequence fill starting at 250, wrapping at 2^8
    logic reset_b, reinit_b, ready_b, busy_b, drop_b;
    logic [NP-1:0] we_i_b, we_o_b;
    addr_vec_t addr_i_b, addr_o_b;
    data_vec_t data_i_b, data_o_b;

    ram_seq_init_write_ctrl #(.DEPTH(D), .INDEX(IX), .WIDTH(W), .NUM_WR_PORTS(NP),
                              .INIT_LANES(4), .RESET_VAL(1'b1), .SEQ_START(250)) u_dut_b (
        .clk(clk), .reset(reset_b), .reinit_i(reinit_b),
        .wrEn_i(we_i_b), .addrWr_i(addr_i_b), .dataWr_i(data_i_b),
        .wrEn_o(we_o_b), .addrWr_o(addr_o_b), .dataWr_o(data_o_b),
        .ramReady_o(ready_b), .initBusy_o(busy_b), .wrDropped_o(drop_b)
    );

    // Instance C: single-lane sequence fill from 0
    logic reset_c, reinit_c, ready_c, busy_c, drop_c;
    logic [NP-1:0] we_i_c, we_o_c;
    addr_vec_t addr_i_c, addr_o_c;
    data_vec_t data_i_c, data_o_c;

    ram_seq_init_write_ctrl #(.DEPTH(D), .INDEX(IX), .WIDTH(W), .NUM_WR_PORTS(NP),
                              .INIT_LANES(1), .RESET_VAL(1'b1), .SEQ_START(0)) u_dut_c (
        .clk(clk), .reset(reset_c), .reinit_i(reinit_c),
        .wrEn_i(we_i_c), .addrWr_i(addr_i_c), .dataWr_i(data_i_c),
        .wrEn_o(we_o_c), .addrWr_o(addr_o_c), .dataWr_o(data_o_c),
        .ramReady_o(ready_c), .initBusy_o(busy_c), .wrDropped_o(drop_c)
    );

    // RAM models, preloaded with 0xEE so a missing fill write is visible
    logic mem_loaded = 1'b0;
    logic [W-1:0] mem_a [D];
    logic [W-1:0] mem_b [D];
    logic [W-1:0] mem_c [D];

    always @(posedge clk) begin
        if (!mem_loaded) begin
            for (int k = 0; k < D; k++) begin
                mem_a[k] <= 8'hEE;
                mem_b[k] <= 8'hEE;
                mem_c[k] <= 8'hEE;
            end
        end else begin
            for (int p = 0; p < NP; p++) begin
                if (we_o_a[p]) mem_a[addr_o_a[p]] <= data_o_a[p];
                if (we_o_b[p]) mem_b[addr_o_b[p]] <= data_o_b[p];
                if (we_o_c[p]) mem_c[addr_o_c[p]] <= data_o_c[p];
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        addr_vec_t exp_addr;
        data_vec_t exp_data;
        int n;

        reset_a = 1'b1; reinit_a = 1'b0; we_i_a = 4'hF; addr_i_a = '0; data_i_a = '0;
        reset_b = 1'b1; reinit_b = 1'b0; we_i_b = '0;   addr_i_b = '0; data_i_b = '0;
        reset_c = 1'b1; reinit_c = 1'b0; we_i_c = '0;   addr_i_c = '0; data_i_c = '0;

        tick();
        mem_loaded = 1'b1;
        tick();
        #1;
        check("rst_wren", 64'(we_o_a), 64'h0);
        check("rst_ready", 64'(ready_a), 64'h0);
        check("rst_busy", 64'(busy_a), 64'h0);
        check("rst_drop", 64'(drop_a), 64'h0);

        // Zero fill with a dropped client write on fill cycle 2
        we_i_a  = '0;
        reset_a = 1'b0;
        for (int c = 0; c < 8; c++) begin
            if (c == 2) begin
                we_i_a = 4'b0001; addr_i_a[0] = 5'd3; data_i_a[0] = 8'hAA;
            end else begin
                we_i_a = '0; addr_i_a = '0; data_i_a = '0;
            end
            #1;
            for (int l = 0; l < NP; l++) exp_addr[l] = IX'(4 * c + l);
            check($sformatf("fill_wren_%0d", c), 64'(we_o_a), 64'hF);
            check($sformatf("fill_addr_%0d", c), 64'(addr_o_a), 64'(exp_addr));
            check($sformatf("fill_data_%0d", c), 64'(data_o_a), 64'h0);
            check($sformatf("fill_busy_%0d", c), 64'(busy_a), 64'h1);
            check($sformatf("fill_ready_%0d", c), 64'(ready_a), 64'h0);
            if (c == 2) check("drop_during_fill", 64'(drop_a), 64'h1);
            tick();
        end
        we_i_a = '0; addr_i_a = '0; data_i_a = '0;
        #1;
        check("zero_ready", 64'(ready_a), 64'h1);
        check("zero_busy", 64'(busy_a), 64'h0);
        for (int k = 0; k < D; k++) check($sformatf("zero_mem_%0d", k), 64'(mem_a[k]), 64'h0);

        // Pass-through in READY
        we_i_a = 4'b1010;
        addr_i_a[1] = 5'd7;  data_i_a[1] = 8'h11;
        addr_i_a[3] = 5'd9;  data_i_a[3] = 8'h22;
        #1;
        exp_addr = '0; exp_addr[1] = 5'd7;  exp_addr[3] = 5'd9;
        exp_data = '0; exp_data[1] = 8'h11; exp_data[3] = 8'h22;
        check("pt_wren", 64'(we_o_a), 64'hA);
        check("pt_addr", 64'(addr_o_a), 64'(exp_addr));
        check("pt_data", 64'(data_o_a), 64'(exp_data));
        check("pt_drop", 64'(drop_a), 64'h0);
        tick();
        we_i_a = '0; addr_i_a = '0; data_i_a = '0;
        #1;
        check("pt_mem7", 64'(mem_a[7]), 64'h11);
        check("pt_mem9", 64'(mem_a[9]), 64'h22);
        check("drop_mem3", 64'(mem_a[3]), 64'h0);

        // reinit in READY: this cycle still passes through, fill starts next cycle
        reinit_a = 1'b1;
        we_i_a = 4'b0100; addr_i_a[2] = 5'd12; data_i_a[2] = 8'h5C;
        #1;
        check("rr_ready_now", 64'(ready_a), 64'h1);
        check("rr_wren_now", 64'(we_o_a), 64'h4);
        tick();
        reinit_a = 1'b0; we_i_a = '0; addr_i_a = '0; data_i_a = '0;
        #1;
        check("rr_ready_next", 64'(ready_a), 64'h0);
        check("rr_busy_next", 64'(busy_a), 64'h1);
        check("rr_ptr_next", 64'(addr_o_a[0]), 64'h0);
        check("rr_mem12", 64'(mem_a[12]), 64'h5C);

        // reinit mid-fill at fill cycle 5
        reset_a = 1'b1;
        tick();
        reset_a = 1'b0;
        for (int c = 0; c < 14; c++) begin
            reinit_a = (c == 5);
            #1;
            check($sformatf("mid_ptr_%0d", c), 64'(addr_o_a[0]), 64'((c < 6) ? 4 * c : 4 * (c - 6)));
            check($sformatf("mid_wren_%0d", c), 64'(we_o_a), 64'hF);
            check($sformatf("mid_ready_%0d", c), 64'(ready_a), 64'h0);
            tick();
        end
        reinit_a = 1'b0;
        #1;
        check("mid_ready_after14", 64'(ready_a), 64'h1);

        // reset together with reinit: reset wins
        reset_a = 1'b1; reinit_a = 1'b1; we_i_a = 4'hF;
        #1;
        check("rst_reinit_wren", 64'(we_o_a), 64'h0);
        check("rst_reinit_ready", 64'(ready_a), 64'h0);
        tick();
        reset_a = 1'b0; reinit_a = 1'b0; we_i_a = '0;
        #1;
        check("rst_reinit_busy", 64'(busy_a), 64'h1);
        check("rst_reinit_ptr", 64'(addr_o_a[0]), 64'h0);

        // Sequence fill with truncation
        reset_b = 1'b0;
        #1;
        exp_data = {8'd253, 8'd252, 8'd251, 8'd250};
        check("seq_first_data", 64'(data_o_b), 64'(exp_data));
        n = 0;
        while (!ready_b && n < 64) begin
            tick();
            n++;
        end
        check("seq_fill_cycles", 64'(n), 64'd8);
        check("seq_mem0", 64'(mem_b[0]), 64'd250);
        check("seq_mem5", 64'(mem_b[5]), 64'd255);
        check("seq_mem6", 64'(mem_b[6]), 64'd0);
        check("seq_mem31", 64'(mem_b[31]), 64'd25);

        // Single-lane instance: initial fill, then reinit from READY
        reset_c = 1'b0;
        #1;
        n = 0;
        while (!ready_c && n < 64) begin
            tick();
            n++;
        end
        check("l1_first_fill_cycles", 64'(n), 64'd32);
        reinit_c = 1'b1;
        #1;
        check("l1_ready_now", 64'(ready_c), 64'h1);
        tick();
        reinit_c = 1'b0;
        for (int c = 0; c < 32; c++) begin
            #1;
            check($sformatf("l1_ready_%0d", c), 64'(ready_c), 64'h0);
            check($sformatf("l1_wren_%0d", c), 64'(we_o_c), 64'h1);
            check($sformatf("l1_addr_%0d", c), 64'(addr_o_c[0]), 64'(c));
            check($sformatf("l1_data_%0d", c), 64'(data_o_c[0]), 64'(c));
            tick();
        end
        #1;
        check("l1_ready_after32", 64'(ready_c), 64'h1);
        check("l1_mem0", 64'(mem_c[0]), 64'd0);
        check("l1_mem17", 64'(mem_c[17]), 64'd17);
        check("l1_mem31", 64'(mem_c[31]), 64'd31);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
